// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue/collect stage.
// Holds op codes, FSM states and the request entry layout.
// Optional build macro: ALU_ISSUE_ACC_EN adds a use_acc bit to req_t.
package alu_issue_pkg;

  localparam int ALU_WIDTH = 5;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
    logic [1:0]           sel;
`ifdef ALU_ISSUE_ACC_EN
    logic                 use_acc;
`endif
  } req_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle for alu_issue_ctrl.
// master: requester/consumer side; slave: the issue stage.
// Optional build macro: ALU_ISSUE_ACC_EN adds req_use_acc.
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 5
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [1:0]       req_sel;
`ifdef ALU_ISSUE_ACC_EN
  logic             req_use_acc;
`endif
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [1:0]       rsp_sel;
  logic             rsp_zero;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_sel,
`ifdef ALU_ISSUE_ACC_EN
    output req_use_acc,
`endif
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_sel,
    input  rsp_zero
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_sel,
`ifdef ALU_ISSUE_ACC_EN
    input  req_use_acc,
`endif
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_sel,
    output rsp_zero
  );

endinterface

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO, no bypass; push ignored when full.
// Ports: i_push/i_din, i_pop/o_dout (head), o_full, o_empty, o_count.
module alu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/collect stage around a combinational ALU: FIFO -> regs -> ALU -> rsp.
// Ports: clk, rst_n, bus (slave), alu_a/b/sel out, alu_out in, busy.
// Optional build macro: ALU_ISSUE_ACC_EN (accumulator-sourced operand A).
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_ctrl_if.slave  bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy
);

  localparam int EW = $bits(req_t);

  state_e                  r_state;
  state_e                  w_next;
  logic                    w_pop;
  logic                    w_cap;
  logic                    w_push;
  logic                    w_full;
  logic                    w_empty;
  logic [$clog2(DEPTH):0]  w_count;
  req_t                    w_in;
  req_t                    w_head;
  logic [EW-1:0]           w_dout;
  logic [WIDTH-1:0]        r_alu_a;
  logic [WIDTH-1:0]        r_alu_b;
  logic [1:0]              r_alu_sel;
  logic [WIDTH-1:0]        r_rsp_data;
  logic [1:0]              r_rsp_sel;
`ifdef ALU_ISSUE_ACC_EN
  logic [WIDTH-1:0]        r_acc;
`endif

  assign w_in.a   = bus.req_a;
  assign w_in.b   = bus.req_b;
  assign w_in.sel = bus.req_sel;
`ifdef ALU_ISSUE_ACC_EN
  assign w_in.use_acc = bus.req_use_acc;
`endif
  assign w_head = w_dout;

  assign w_push        = bus.req_valid && !w_full;
  assign bus.req_ready = !w_full;

  alu_req_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_in),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_cap  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = DRIVE;
        end
      end
      DRIVE: begin
        w_cap  = 1'b1;
        w_next = HOLD;
      end
      HOLD: begin
        if (bus.rsp_ready) begin
          w_pop  = !w_empty;
          w_next = w_empty ? IDLE : DRIVE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_sel  <= '0;
      r_rsp_data <= '0;
      r_rsp_sel  <= '0;
`ifdef ALU_ISSUE_ACC_EN
      r_acc      <= '0;
`endif
    end else begin
      if (w_pop) begin
`ifdef ALU_ISSUE_ACC_EN
        r_alu_a <= w_head.use_acc ? r_acc : w_head.a;
`else
        r_alu_a <= w_head.a;
`endif
        r_alu_b   <= w_head.b;
        r_alu_sel <= w_head.sel;
      end
      if (w_cap) begin
        r_rsp_data <= alu_out;
        r_rsp_sel  <= r_alu_sel;
`ifdef ALU_ISSUE_ACC_EN
        r_acc      <= alu_out;
`endif
      end
    end
  end

  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_sel = r_alu_sel;

  assign bus.rsp_valid = (r_state == HOLD);
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_sel   = r_rsp_sel;
  // Gated so the flag reads 0 out of reset; identical whenever rsp_valid=1.
  assign bus.rsp_zero  = bus.rsp_valid && (r_rsp_data == '0);

  assign busy = (w_count != '0) || (r_state != IDLE);

endmodule
